// File: rtl/sobel_frame_ctrl_if.sv
// sobel_frame_ctrl_if: camera-side capture signals and processor-side pixel stream
interface sobel_frame_ctrl_if;
  logic        cam_vsync;
  logic        cam_href;
  logic [15:0] cam_pixel;
  logic        proc_vsync;
  logic        proc_href;
  logic [15:0] proc_pixel;
  logic        proc_sobel_enable;
  logic        proc_pixel_valid;
  modport master (
    input  cam_vsync, cam_href, cam_pixel, proc_pixel_valid,
    output proc_vsync, proc_href, proc_pixel, proc_sobel_enable
  );
  modport slave (
    output cam_vsync, cam_href, cam_pixel, proc_pixel_valid,
    input  proc_vsync, proc_href, proc_pixel, proc_sobel_enable
  );
endinterface

// File: rtl/sobel_frame_ctrl.sv
// sobel_frame_ctrl: frame sequencer for sobel_processor; SOBEL_CTRL_TIMEOUT_EN enables the href watchdog
module sobel_frame_ctrl #(
  parameter int IMG_WIDTH      = 640,
  parameter int IMG_HEIGHT     = 480,
  parameter int DRAIN_CYCLES   = 64,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  sobel_frame_ctrl_if.master bus,
  input  logic               run,
  input  logic               sobel_req,
  output logic               busy,
  output logic               frame_done,
  output logic               frame_err,
  output logic [3:0]         err_flags,
  output logic [19:0]        out_count,
  output logic [15:0]        frame_cnt
);
  typedef enum logic [1:0] {IDLE, FRAME, DRAIN, DONE} state_t;
  localparam logic [15:0] W   = 16'(IMG_WIDTH);
  localparam logic [15:0] H   = 16'(IMG_HEIGHT);
  localparam logic [15:0] DC  = 16'(DRAIN_CYCLES);
  localparam logic [19:0] EXP = 20'((IMG_HEIGHT - 2) * (IMG_WIDTH - 1));
  state_t      state_q, state_d;
  logic        vs_q, vs_p_q, hr_q, hr_p_q, vs_rise, hr_fall, fin, chk;
  logic [15:0] col_q, col_d, row_q, row_d, quiet_q, quiet_d;
  logic [19:0] cnt_q, cnt_d, oc_q, oc_d;
  logic [1:0]  flg_q, flg_d;
  logic        vsync_q, vsync_d, href_q, href_d, en_q, en_d, done_q, done_d, ferr_q, ferr_d;
  logic [15:0] pixel_q, pixel_d, fc_q, fc_d;
  logic [3:0]  err_q, err_d;
`ifdef SOBEL_CTRL_TIMEOUT_EN
  logic [31:0] to_q, to_d;
  logic        tf_q, tf_d;
`else
  logic        unused_to;
  assign unused_to = ^TIMEOUT_CYCLES;
`endif
  assign vs_rise = vs_q & ~vs_p_q;
  assign hr_fall = hr_p_q & ~hr_q;
  assign busy = state_q == FRAME || state_q == DRAIN;
  assign bus.proc_vsync = vsync_q;
  assign bus.proc_href = href_q;
  assign bus.proc_pixel = pixel_q;
  assign bus.proc_sobel_enable = en_q;
  assign frame_done = done_q;
  assign frame_err = ferr_q;
  assign err_flags = err_q;
  assign out_count = oc_q;
  assign frame_cnt = fc_q;
  always_comb begin
    state_d = state_q;
    col_d = col_q;
    row_d = row_q;
    quiet_d = quiet_q;
    flg_d = flg_q;
    cnt_d = (busy && bus.proc_pixel_valid && cnt_q != '1) ? cnt_q + 20'd1 : cnt_q;
    vsync_d = 1'b0;
    href_d = 1'b0;
    pixel_d = '0;
    en_d = en_q;
    done_d = 1'b0;
    ferr_d = 1'b0;
    err_d = err_q;
    oc_d = oc_q;
    fc_d = fc_q;
    fin = 1'b0;
    chk = 1'b0;
`ifdef SOBEL_CTRL_TIMEOUT_EN
    to_d = to_q;
    tf_d = tf_q;
`endif
    if (state_q == FRAME) begin
      href_d = bus.cam_href && col_q < W && row_q < H;
      pixel_d = href_d ? bus.cam_pixel : '0;
      col_d = hr_fall ? '0 : col_q + {15'd0, bus.cam_href};
      row_d = hr_fall ? row_q + 16'd1 : row_q;
      flg_d[0] = flg_q[0] | (hr_fall && col_q != W);
      flg_d[1] = vs_rise;
      state_d = (hr_fall && row_d == H) ? DRAIN : FRAME;
      quiet_d = '0;
`ifdef SOBEL_CTRL_TIMEOUT_EN
      to_d = bus.cam_href ? '0 : to_q + 32'd1;
      if (to_d == 32'(TIMEOUT_CYCLES)) begin
        tf_d = 1'b1;
        state_d = DRAIN;
      end
`endif
      fin = vs_rise;
    end else if (state_q == DRAIN) begin
      quiet_d = bus.proc_pixel_valid ? '0 : quiet_q + 16'd1;
      state_d = quiet_d == DC ? DONE : DRAIN;
      fin = vs_rise;
      chk = vs_rise;
    end else if (state_q == DONE) begin
      fin = 1'b1;
      chk = 1'b1;
    end
    if (fin) begin
      err_d = {1'b0, chk && cnt_q != EXP, flg_d};
`ifdef SOBEL_CTRL_TIMEOUT_EN
      err_d[3] = tf_d;
`endif
      oc_d = cnt_q;
      done_d = 1'b1;
      ferr_d = |err_d;
      fc_d = fc_q + 16'd1;
      state_d = IDLE;
    end
    if ((state_q == IDLE || fin) && vs_rise && run) begin
      state_d = FRAME;
      en_d = sobel_req;
      col_d = '0;
      row_d = '0;
      quiet_d = '0;
      cnt_d = '0;
      flg_d = '0;
      vsync_d = 1'b1;
`ifdef SOBEL_CTRL_TIMEOUT_EN
      to_d = '0;
      tf_d = 1'b0;
`endif
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      {vs_q, vs_p_q, hr_q, hr_p_q} <= '0;
      {col_q, row_q, quiet_q, cnt_q, oc_q, flg_q} <= '0;
      {vsync_q, href_q, en_q, done_q, ferr_q} <= '0;
      {pixel_q, fc_q, err_q} <= '0;
`ifdef SOBEL_CTRL_TIMEOUT_EN
      to_q <= '0;
      tf_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      vs_q <= bus.cam_vsync;
      vs_p_q <= vs_q;
      hr_q <= bus.cam_href;
      hr_p_q <= hr_q;
      col_q <= col_d;
      row_q <= row_d;
      quiet_q <= quiet_d;
      cnt_q <= cnt_d;
      oc_q <= oc_d;
      flg_q <= flg_d;
      vsync_q <= vsync_d;
      href_q <= href_d;
      en_q <= en_d;
      done_q <= done_d;
      ferr_q <= ferr_d;
      pixel_q <= pixel_d;
      fc_q <= fc_d;
      err_q <= err_d;
`ifdef SOBEL_CTRL_TIMEOUT_EN
      to_q <= to_d;
      tf_q <= tf_d;
`endif
    end
  end
endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// tb_sobel_frame_ctrl: directed frame sequences against an 8x6 sobel_frame_ctrl
module tb_sobel_frame_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run = 1'b0;
  logic sobel_req = 1'b0;
  logic busy, frame_done, frame_err;
  logic [3:0] err_flags;
  logic [19:0] out_count;
  logic [15:0] frame_cnt;
  int ncmp = 0;
  int nfail = 0;
  int vs_cyc = 0, vs_pul = 0, fwd = 0, fwd_sum = 0, bad_px = 0, busy_cyc = 0, dn = 0, ferr_bad = 0;
  logic vs_prev = 1'b0;
  logic [4:0] hist_err[$];
  logic [19:0] hist_oc[$];
  sobel_frame_ctrl_if bus ();
  sobel_frame_ctrl #(
    .IMG_WIDTH(8), .IMG_HEIGHT(6), .DRAIN_CYCLES(4), .TIMEOUT_CYCLES(4096)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .run(run), .sobel_req(sobel_req),
    .busy(busy), .frame_done(frame_done), .frame_err(frame_err),
    .err_flags(err_flags), .out_count(out_count), .frame_cnt(frame_cnt)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    vs_prev <= bus.proc_vsync;
    if (bus.proc_vsync) vs_cyc <= vs_cyc + 1;
    if (bus.proc_vsync && !vs_prev) vs_pul <= vs_pul + 1;
    if (bus.proc_href) begin
      fwd <= fwd + 1;
      fwd_sum <= fwd_sum + int'(bus.proc_pixel);
    end
    if ((bus.proc_href && (bus.proc_pixel[3:0] == 4'd0 || bus.proc_pixel[3:0] > 4'd8)) ||
        (!bus.proc_href && bus.proc_pixel != '0)) bad_px <= bad_px + 1;
    if (busy) busy_cyc <= busy_cyc + 1;
    if (frame_done) begin
      dn <= dn + 1;
      hist_err.push_back({frame_err, err_flags});
      hist_oc.push_back(out_count);
    end
    if (frame_err !== (frame_done && |err_flags)) ferr_bad <= ferr_bad + 1;
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic send_vsync();
    bus.cam_vsync = 1'b1;
    tick(2);
    bus.cam_vsync = 1'b0;
    tick(3);
  endtask
  task automatic send_lines(input int nl, input int longl, input int nv, input int flip, input int stop);
    for (int r = 0; r < nl; r++) begin
      if (r == flip) sobel_req = 1'b0;
      if (r == stop) run = 1'b0;
      for (int c = 0; c < (r == longl ? 10 : 8); c++) begin
        bus.cam_href = 1'b1;
        bus.cam_pixel = 16'(r * 16 + c + 1);
        tick(1);
      end
      bus.cam_href = 1'b0;
      bus.cam_pixel = '0;
      if (r == nl - 1 && nv > 0) begin
        bus.proc_pixel_valid = 1'b1;
        tick(nv);
        bus.proc_pixel_valid = 1'b0;
      end
      tick(4);
    end
  endtask
  task automatic wait_done(input int target);
    int k;
    k = 0;
    while (dn < target && k < 300) begin
      tick(1);
      k++;
    end
    check("done_wait", 32'(dn >= target), 1);
  endtask
  initial begin
    int b_vp, b_vc, b_fw, b_fs, b_dn, b_busy;
    bus.cam_vsync = 1'b0;
    bus.cam_href = 1'b0;
    bus.cam_pixel = '0;
    bus.proc_pixel_valid = 1'b0;
    tick(2);
    check("rst_vsync", 32'(bus.proc_vsync), 0);
    check("rst_href", 32'(bus.proc_href), 0);
    check("rst_pixel", 32'(bus.proc_pixel), 0);
    check("rst_en", 32'(bus.proc_sobel_enable), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(frame_done), 0);
    check("rst_ferr", 32'(frame_err), 0);
    check("rst_err", 32'(err_flags), 0);
    check("rst_oc", 32'(out_count), 0);
    check("rst_fcnt", 32'(frame_cnt), 0);
    rst_n = 1'b1;
    run = 1'b1;
    sobel_req = 1'b1;
    tick(2);
    // clean frame; sobel_req drops during line 2
    send_vsync();
    send_lines(6, -1, 28, 2, -1);
    wait_done(1);
    tick(1);
    check("f1_vs_pulses", 32'(vs_pul), 1);
    check("f1_vs_cycles", 32'(vs_cyc), 1);
    check("f1_fwd", 32'(fwd), 48);
    check("f1_sum", 32'(fwd_sum), 2136);
    check("f1_err", 32'(hist_err[0]), 0);
    check("f1_oc", 32'(hist_oc[0]), 28);
    check("f1_fcnt", 32'(frame_cnt), 1);
    check("f1_en", 32'(bus.proc_sobel_enable), 1);
    check("f1_busy", 32'(busy), 0);
    // frame 2 latches the dropped request at its vsync
    send_vsync();
    check("f2_en_at_start", 32'(bus.proc_sobel_enable), 0);
    check("f2_busy", 32'(busy), 1);
    send_lines(6, -1, 28, -1, -1);
    wait_done(2);
    tick(1);
    check("f2_err", 32'(hist_err[1]), 0);
    check("f2_fcnt", 32'(frame_cnt), 2);
    // long line 3 clipped to 8 pixels
    sobel_req = 1'b1;
    b_fw = fwd;
    b_fs = fwd_sum;
    send_vsync();
    check("f3_en", 32'(bus.proc_sobel_enable), 1);
    send_lines(6, 3, 28, -1, -1);
    wait_done(3);
    tick(1);
    check("f3_fwd", 32'(fwd - b_fw), 48);
    check("f3_sum", 32'(fwd_sum - b_fs), 2136);
    check("f3_err", 32'(hist_err[2]), 32'h11);
    check("f3_oc", 32'(hist_oc[2]), 28);
    // too many output valids -> count mismatch
    send_vsync();
    send_lines(6, -1, 35, -1, -1);
    wait_done(4);
    tick(1);
    check("f4_err", 32'(hist_err[3]), 32'h14);
    check("f4_oc", 32'(out_count), 35);
    check("f4_fcnt", 32'(frame_cnt), 4);
    // premature vsync after 3 lines, then a clean frame
    b_vp = vs_pul;
    b_fw = fwd;
    b_fs = fwd_sum;
    send_vsync();
    send_lines(3, -1, 0, -1, -1);
    send_vsync();
    send_lines(6, -1, 28, -1, -1);
    wait_done(6);
    tick(1);
    check("ab_err", 32'(hist_err[4]), 32'h12);
    check("ab_oc", 32'(hist_oc[4]), 0);
    check("ab_next_err", 32'(hist_err[5]), 0);
    check("ab_next_oc", 32'(hist_oc[5]), 28);
    check("ab_vs_pulses", 32'(vs_pul - b_vp), 2);
    check("ab_fwd", 32'(fwd - b_fw), 72);
    check("ab_sum", 32'(fwd_sum - b_fs), 2628);
    check("ab_fcnt", 32'(frame_cnt), 6);
    // run drops mid-frame: frame finishes, next vsync ignored
    send_vsync();
    send_lines(6, -1, 28, -1, 2);
    wait_done(7);
    tick(1);
    check("r0_err", 32'(hist_err[6]), 0);
    check("r0_fcnt", 32'(frame_cnt), 7);
    b_vc = vs_cyc;
    b_fw = fwd;
    b_dn = dn;
    b_busy = busy_cyc;
    send_vsync();
    send_lines(6, -1, 0, -1, -1);
    tick(10);
    check("r0_vs", 32'(vs_cyc - b_vc), 0);
    check("r0_fwd", 32'(fwd - b_fw), 0);
    check("r0_busy", 32'(busy_cyc - b_busy), 0);
    check("r0_done", 32'(dn - b_dn), 0);
    check("r0_fcnt_hold", 32'(frame_cnt), 7);
    // reset in the middle of line 1
    run = 1'b1;
    send_vsync();
    send_lines(1, -1, 0, -1, -1);
    for (int c = 0; c < 4; c++) begin
      bus.cam_href = 1'b1;
      bus.cam_pixel = 16'(16 + c + 1);
      tick(1);
    end
    check("pre_rst_href", 32'(bus.proc_href), 1);
    b_dn = dn;
    rst_n = 1'b0;
    #1;
    check("mid_rst_href", 32'(bus.proc_href), 0);
    check("mid_rst_pixel", 32'(bus.proc_pixel), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_en", 32'(bus.proc_sobel_enable), 0);
    check("mid_rst_fcnt", 32'(frame_cnt), 0);
    check("mid_rst_oc", 32'(out_count), 0);
    bus.cam_href = 1'b0;
    bus.cam_pixel = '0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    check("mid_rst_nodone", 32'(dn - b_dn), 0);
    send_vsync();
    send_lines(6, -1, 28, -1, -1);
    wait_done(b_dn + 1);
    tick(1);
    check("post_rst_fcnt", 32'(frame_cnt), 1);
    check("post_rst_err", 32'(err_flags), 0);
    check("post_rst_oc", 32'(out_count), 28);
    check("pixel_clip_zero", 32'(bad_px), 0);
    check("ferr_coincident", 32'(ferr_bad), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
